// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor and adder).
// Holds the FSM state encoding and the bit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // The counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice for WIDTH >= 2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: Diff = A - B - Bin, with borrow-out.
// Purely combinational; the serial datapath reuses one instance every cycle.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic w_axb;

  assign w_axb = A ^ B;
  assign Diff  = w_axb ^ Bin;
  assign Bout  = (~A & B) | (~w_axb & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin over WIDTH cycles, LSB first.
// Handshake: start is accepted only while busy = 0 (IDLE or DONE); done pulses for one cycle when results update.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  serial_state_e    r_state;
  serial_state_e    w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_borrow),
    .Diff (w_d),
    .Bout (w_bout)
  );

  assign w_last     = (r_cnt == LAST_CNT);
  assign w_accept   = start && (r_state != RUN);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operands shift right so bit 0 always feeds the cell; results enter at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_borrow <= Bin;
      r_res    <= '0;
      r_cnt    <= '0;
      r_a_msb  <= A[WIDTH-1];
      r_b_msb  <= B[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_bout;
        r_ovf  <= (r_a_msb ^ r_b_msb) & (w_res_next[WIDTH-1] ^ r_a_msb);
        r_zero <= (w_res_next == '0);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign Diff = r_diff;
  assign Bout = r_bout;
  assign Ovf  = r_ovf;
  assign Zero = r_zero;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing Diff = A − B − Bin over WIDTH clock cycles with a start/done handshake. It is the inverse arithmetic counterpart to the parallel ripple-carry adder: it trades latency for a single full-subtractor cell. It sits beside the adder in the arithmetic datapath, where area matters more than latency. Results are registered and held until the next operation completes.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only while busy = 0.
- A  input  WIDTH  minuend; latched on an accepted start.
- B  input  WIDTH  subtrahend; latched on an accepted start.
- Bin  input  1  borrow-in; latched on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse marking that the result outputs have just updated.
- Diff  output  WIDTH  (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  final borrow; 1 iff A < B + Bin, treating A and B as unsigned.
- Ovf  output  1  two's-complement overflow.
- Zero  output  1  high iff Diff == 0.

## Operation
- FSM states:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - DONE: busy = 0, done = 1.
- Transitions:
  - IDLE, start = 1 → RUN. The block latches A and B into shift registers and Bin into the borrow register, and clears the bit counter to 0.
  - RUN, counter < WIDTH−1 → RUN. Each cycle the full_subtractor processes bit 0 of each operand shift register together with the borrow register. The difference bit is shifted into the MSB of the result shift register (shift right). Both operand registers shift right. The borrow register takes the cell's borrow-out. The counter increments.
  - RUN, counter == WIDTH−1 → DONE. The final bit is processed in this cycle. Diff, Bout, Ovf and Zero are written from the completed result at this edge.
  - DONE, start = 1 → RUN, accepted exactly as from IDLE. This gives back-to-back operation.
  - DONE, start = 0 → IDLE.
- start while busy = 1: ignored. Operands are not re-latched and the current run is unaffected.
- Flags:
  - Ovf = (A[WIDTH−1] ≠ B[WIDTH−1]) & (Diff[WIDTH−1] ≠ A[WIDTH−1]), using the latched A and B.
  - Zero is computed from the final Diff.
- Diff, Bout, Ovf and Zero hold their values until the next DONE entry or until reset.
- Reset (any state, including mid-RUN):
  - next state IDLE.
  - busy = 0, done = 0, Diff = 0, Bout = 0, Ovf = 0, Zero = 0.
  - counter, shift registers and borrow register cleared.
  - The aborted run produces no done pulse.
- rst takes priority over start in the same cycle.

## Timing
- start is accepted at clock edge t. busy rises at t and stays high for exactly WIDTH cycles.
- At edge t+WIDTH: busy falls, done rises, and the result outputs update.
- At edge t+WIDTH+1: done falls. If start was high during the done cycle, busy rises again at this same edge.
- Latency is WIDTH cycles from the accepting edge to valid outputs.
- Maximum throughput is one result per WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package serial_arith_pkg contains:
  - the FSM state encoding localparams (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the counter-width constant, derived as $clog2(WIDTH).
- The serial adder variant will reuse this package.
- Sub-module full_subtractor, purely combinational, instantiated once:
  - inputs A, B, Bin; outputs Diff, Bout;
  - Diff = A^B^Bin;
  - Bout = (~A & B) | (~(A^B) & Bin).

## Test plan
WIDTH = 8 throughout.
- A=0x05, B=0x03, Bin=0, start pulsed → busy high for 8 cycles, then done pulses for 1 cycle with Diff=0x02, Bout=0, Ovf=0, Zero=0.
- A=0x00, B=0x01, Bin=0 → Diff=0xFF, Bout=1, Ovf=0, Zero=0.
- A=0x80, B=0x01, Bin=0 → Diff=0x7F, Bout=0, Ovf=1. Then A=0x7F, B=0xFF → Diff=0x80, Bout=1, Ovf=1.
- A=0x10, B=0x0F, Bin=1 → Diff=0x00, Zero=1, Bout=0. Then start held high through the done cycle with A=0x03, B=0x01 → busy re-rises on the edge done falls, and the second result is Diff=0x02.
- Start with A=0x05, B=0x03; pulse start again at cycle 3 with A=0xFF, B=0x00 → the second start is ignored and the result is Diff=0x02.
- Start, then assert rst during cycle 4 of RUN → next cycle busy=0, done=0 and all outputs are 0; no done pulse follows. A subsequent start completes normally.
